suprloco_video_monitor: RTL and testbench
=========================================

// Module: suprloco_video_monitor
// PURPOSE
//  Frame-signature monitor for the board's pixel-stream output (CEN/EN/RGB333).
//  Sits beside the screen simulator on the same stream, or in the core as a debug tap.
//  Per frame it measures active geometry and computes a CRC-16 over every active pixel.
//  Result is latched with a one-cycle valid pulse, so benches/CI compare frames against golden signatures.
// PARAMETERS
//  EXP_W      256   expected active pixels per line
//  EXP_H      224   expected active lines per frame
//  FRAME_GAP  2048  consecutive CEN samples with EN=0 that declare vblank/frame end
// PORTS
//  i_EMU_MCLK     in   1   master clock, 40 MHz
//  i_EMU_RST_n    in   1   asynchronous active-low reset
//  i_VIDEO_CEN    in   1   pixel clock enable; inputs sampled only when 1
//  i_VIDEO_EN     in   1   active-video flag
//  i_VIDEO_R/G/B  in   3   pixel colour, each channel
//  o_FRAME_VALID  out  1   one-MCLK pulse, result registers just updated
//  o_FRAME_CRC    out  16  CRC of last complete frame
//  o_LINE_CNT     out  10  active lines in last frame
//  o_PIX_CNT      out  10  active pixels in last line of last frame
//  o_ERR_W        out  1   some line in last frame had width != EXP_W
//  o_ERR_H        out  1   last frame line count != EXP_H
//  o_FRAME_NUM    out  16  completed-frame counter
// BEHAVIOUR
//  - Reset: all outputs 0; internal CRC = 16'hFFFF; counters 0; state SYNC.
//  - The FSM advances only on cycles with i_VIDEO_CEN=1. A "sample" is one such cycle.
//  - States:
//    - SYNC: discard stream until the gap counter reaches FRAME_GAP, then go to VBLANK.
//      The first reported frame is therefore always whole.
//    - VBLANK: on EN=1 -> ACTIVE; that sample is pixel 0 of line 0.
//    - ACTIVE: on EN=0 -> HBLANK and close the line:
//      - line_cnt+1;
//      - last_w = pix_cnt;
//      - if pix_cnt != EXP_W, set sticky err_w.
//    - HBLANK: on EN=1 -> ACTIVE, pix_cnt restarts at 1.
//      If gap reaches FRAME_GAP first -> frame end -> VBLANK.
//  - Gap counter:
//    - +1 on each sample with EN=0; cleared on any sample with EN=1.
//    - Saturates at FRAME_GAP.
//    - Frame end = the EN=0 sample where gap goes FRAME_GAP-1 -> FRAME_GAP.
//  - Frame end, on the next MCLK edge:
//    - latch o_FRAME_CRC, o_LINE_CNT, o_PIX_CNT=last_w, o_ERR_W=err_w;
//    - o_ERR_H = (line_cnt != EXP_H);
//    - o_FRAME_NUM+1, wrapping at 16'hFFFF -> 0;
//    - o_FRAME_VALID=1 for exactly that one cycle;
//    - re-init CRC=FFFF, line_cnt=0, err_w=0.
//  - CRC: CRC-16-CCITT, poly 16'h1021, init FFFF, no reflection, no final XOR.
//    - Each active sample folds in 9 bits {R,G,B}, MSB (R[2]) first.
//    - All 9 bit steps complete combinationally in the same sample.
//  - Widths:
//    - pix_cnt and line_cnt are 10 bits, saturating at 1023 (no wrap).
//    - A saturated count always mismatches EXP_W/EXP_H.
//  - Boundary cases:
//    - A 1-sample EN=0 blip inside a line counts as a line end plus a new line.
//    - HBLANK shorter than FRAME_GAP never ends a frame.
//    - A frame with zero active lines cannot occur; VBLANK waits for EN.
//    - CEN=0 cycles freeze all state; o_FRAME_VALID still drops after 1 MCLK.
//  - Reset mid-frame: async clear, back to SYNC. The partial frame is never reported.
//  - Latency: frame end sample -> o_FRAME_VALID high 1 MCLK later.
// STRUCTURE
//  - Package suprloco_vmon_pkg holds:
//    - state enum {SYNC,VBLANK,ACTIVE,HBLANK};
//    - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF;
//    - function crc16_step9(crc, data9).
//  - One sub-module: suprloco_crc16_9b (combinational next-CRC, 16b crc + 9b data -> 16b).
//  - The top holds the FSM, counters and result registers.
// TESTING
//  1. Reset, 3 frames of 256x224, HBLANK 128 samples, VBLANK 4000 samples.
//     -> 2 valid pulses (first frame eaten by SYNC);
//     -> LINE_CNT=224, PIX_CNT=256, ERR_W=0, ERR_H=0, FRAME_NUM=1 then 2.
//  2. All-black frame vs gradient frame R=x[2:0],G=y[2:0],B=x[5:3].
//     -> CRC matches bench model for each; the two CRCs differ.
//     -> Same frame repeated gives an identical CRC.
//  3. Line 100 is 255 pixels wide.
//     -> ERR_W=1, ERR_H=0, that frame only; next clean frame -> ERR_W=0.
//  4. Frame with 223 lines -> ERR_H=1, LINE_CNT=223.
//     A 1200-line frame -> LINE_CNT=1023 (saturated), ERR_H=1.
//  5. CEN asserted every 7th MCLK (CEN=0 cycles in between).
//     -> results identical to test 1; VALID width exactly 1 MCLK.
//  6. Assert RST_n low mid-line 50; release; stream continues.
//     -> outputs 0, no VALID for the partial frame; next whole frame reports FRAME_NUM=1.

Source files
------------

// File: rtl/suprloco_vmon_pkg.sv
// Shared types, constants and the bit-serial CRC step used by the
// SuprLoco video frame-signature monitor.
package suprloco_vmon_pkg;

  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, HBLANK} vmon_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int                CNT_W   = 10;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // CRC-16-CCITT over one 9-bit {R,G,B} pixel, MSB first, no reflection.
  function automatic logic [15:0] crc16_step9(input logic [15:0] crc,
                                              input logic [8:0]  data9);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 8; i >= 0; i--) begin
      fb = c[15] ^ data9[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/suprloco_crc16_9b.sv
// Combinational next-CRC: folds one 9-bit pixel into a running CRC-16.
module suprloco_crc16_9b
  import suprloco_vmon_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [8:0]  i_data,
  output logic [15:0] o_crc
);

  assign o_crc = crc16_step9(i_crc, i_data);

endmodule

// File: rtl/suprloco_video_monitor.sv
// Frame-signature monitor: measures active geometry of each frame of a
// CEN/EN/RGB333 pixel stream and reports a CRC-16 over its active pixels.
module suprloco_video_monitor
  import suprloco_vmon_pkg::*;
#(
  parameter int EXP_W     = 256,
  parameter int EXP_H     = 224,
  parameter int FRAME_GAP = 2048
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST_n,
  input  logic        i_VIDEO_CEN,
  input  logic        i_VIDEO_EN,
  input  logic [2:0]  i_VIDEO_R,
  input  logic [2:0]  i_VIDEO_G,
  input  logic [2:0]  i_VIDEO_B,
  output logic        o_FRAME_VALID,
  output logic [15:0] o_FRAME_CRC,
  output logic [9:0]  o_LINE_CNT,
  output logic [9:0]  o_PIX_CNT,
  output logic        o_ERR_W,
  output logic        o_ERR_H,
  output logic [15:0] o_FRAME_NUM
);

  localparam int               GAP_W    = $clog2(FRAME_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(FRAME_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
  localparam logic [CNT_W-1:0] EXP_W_C  = CNT_W'(EXP_W);
  localparam logic [CNT_W-1:0] EXP_H_C  = CNT_W'(EXP_H);

  vmon_state_e      r_state, w_next_state;
  logic [GAP_W-1:0] r_gap;
  logic [CNT_W-1:0] r_pix, r_line, r_last_w, w_line_inc;
  logic             r_err_w;
  logic [15:0]      r_crc, w_crc_next;
  logic [8:0]       w_pix_data;
  logic             w_gap_hit, w_fold, w_pix_restart, w_pix_inc;
  logic             w_line_close, w_frame_end;

  logic             r_frame_valid, r_res_err_w, r_res_err_h;
  logic [15:0]      r_res_crc, r_frame_num;
  logic [CNT_W-1:0] r_res_line, r_res_pix;

  assign w_pix_data = {i_VIDEO_R, i_VIDEO_G, i_VIDEO_B};
  assign w_gap_hit  = i_VIDEO_CEN && !i_VIDEO_EN && (r_gap == GAP_LAST);
  assign w_line_inc = (r_line == CNT_MAX) ? r_line : r_line + CNT_W'(1);

  suprloco_crc16_9b u_crc (
    .i_crc  (r_crc),
    .i_data (w_pix_data),
    .o_crc  (w_crc_next)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) r_state <= SYNC;
    else              r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_fold        = 1'b0;
    w_pix_restart = 1'b0;
    w_pix_inc     = 1'b0;
    w_line_close  = 1'b0;
    w_frame_end   = 1'b0;
    if (i_VIDEO_CEN) begin
      unique case (r_state)
        SYNC:   if (w_gap_hit) w_next_state = VBLANK;
        VBLANK: if (i_VIDEO_EN) begin
          w_next_state  = ACTIVE;
          w_fold        = 1'b1;
          w_pix_restart = 1'b1;
        end
        ACTIVE: if (i_VIDEO_EN) begin
          w_fold    = 1'b1;
          w_pix_inc = 1'b1;
        end else begin
          w_next_state = HBLANK;
          w_line_close = 1'b1;
        end
        HBLANK: if (i_VIDEO_EN) begin
          w_next_state  = ACTIVE;
          w_fold        = 1'b1;
          w_pix_restart = 1'b1;
        end else if (w_gap_hit) begin
          w_next_state = VBLANK;
          w_frame_end  = 1'b1;
        end
        default: w_next_state = SYNC;
      endcase
    end
  end

  // Blanking-run length; saturates so a long vblank never re-triggers frame end.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      r_gap <= '0;
    end else if (i_VIDEO_CEN) begin
      if (i_VIDEO_EN)            r_gap <= '0;
      else if (r_gap != GAP_END) r_gap <= r_gap + GAP_W'(1);
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      r_crc    <= CRC_INIT;
      r_pix    <= '0;
      r_line   <= '0;
      r_last_w <= '0;
      r_err_w  <= 1'b0;
    end else begin
      if (w_fold) r_crc <= w_crc_next;

      if (w_pix_restart)                      r_pix <= CNT_W'(1);
      else if (w_pix_inc && r_pix != CNT_MAX) r_pix <= r_pix + CNT_W'(1);

      if (w_line_close) begin
        r_line   <= w_line_inc;
        r_last_w <= r_pix;
        if (r_pix != EXP_W_C || r_pix == CNT_MAX) r_err_w <= 1'b1;
      end

      if (w_frame_end) begin
        r_crc   <= CRC_INIT;
        r_line  <= '0;
        r_err_w <= 1'b0;
      end
    end
  end

  // Result registers change only at frame end; the valid strobe lasts one MCLK.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      r_frame_valid <= 1'b0;
      r_res_crc     <= '0;
      r_res_line    <= '0;
      r_res_pix     <= '0;
      r_res_err_w   <= 1'b0;
      r_res_err_h   <= 1'b0;
      r_frame_num   <= '0;
    end else begin
      r_frame_valid <= w_frame_end;
      if (w_frame_end) begin
        r_res_crc   <= r_crc;
        r_res_line  <= r_line;
        r_res_pix   <= r_last_w;
        r_res_err_w <= r_err_w;
        r_res_err_h <= (r_line != EXP_H_C) || (r_line == CNT_MAX);
        r_frame_num <= r_frame_num + 16'd1;
      end
    end
  end

  assign o_FRAME_VALID = r_frame_valid;
  assign o_FRAME_CRC   = r_res_crc;
  assign o_LINE_CNT    = r_res_line;
  assign o_PIX_CNT     = r_res_pix;
  assign o_ERR_W       = r_res_err_w;
  assign o_ERR_H       = r_res_err_h;
  assign o_FRAME_NUM   = r_frame_num;

endmodule

// File: tb/tb_suprloco_video_monitor.sv
// Self-checking bench for suprloco_video_monitor. Geometry is scaled down
// (16x12, gap 64) so whole multi-frame sequences stay short.
module tb_suprloco_video_monitor;

  localparam int TW   = 16;
  localparam int TH   = 12;
  localparam int TGAP = 64;
  localparam int VBL  = 100;
  localparam int PAT_BLACK = 0;
  localparam int PAT_GRAD  = 1;

  typedef struct {
    logic       rst_before;
    int         cen_gap;
    int         lines;
    int         width;
    int         hblank;
    int         bad_line;
    int         bad_w;
    int         pattern;
    logic       reported;
    logic [9:0] exp_lines;
    logic [9:0] exp_pix;
    logic       exp_err_w;
    logic       exp_err_h;
  } frame_vec_t;

  typedef struct {
    int          id;
    logic [15:0] crc;
    logic [9:0]  lines;
    logic [9:0]  pix;
    logic        err_w;
    logic        err_h;
    logic [15:0] num;
  } sb_entry_t;

  logic       clk, rst_n, cen, en;
  logic [8:0] rgb;
  logic       o_valid, o_err_w, o_err_h;
  logic [15:0] o_crc, o_num;
  logic [9:0] o_lines, o_pix;

  int          n_checks, n_errors, cen_gap;
  logic [15:0] exp_num;
  logic        prev_valid;
  sb_entry_t   sb_q[$];
  sb_entry_t   mon_e;
  logic [15:0] seen_crc [0:15];
  frame_vec_t  vecs [0:11];
  frame_vec_t  tail;

  suprloco_video_monitor #(.EXP_W(TW), .EXP_H(TH), .FRAME_GAP(TGAP)) dut (
    .i_EMU_MCLK    (clk),
    .i_EMU_RST_n   (rst_n),
    .i_VIDEO_CEN   (cen),
    .i_VIDEO_EN    (en),
    .i_VIDEO_R     (rgb[8:6]),
    .i_VIDEO_G     (rgb[5:3]),
    .i_VIDEO_B     (rgb[2:0]),
    .o_FRAME_VALID (o_valid),
    .o_FRAME_CRC   (o_crc),
    .o_LINE_CNT    (o_lines),
    .o_PIX_CNT     (o_pix),
    .o_ERR_W       (o_err_w),
    .o_ERR_H       (o_err_h),
    .o_FRAME_NUM   (o_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference CRC: shift register form of x^16+x^12+x^5+1, message bit MSB first.
  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [8:0] d);
    logic [15:0] r;
    logic        top;
    r = c;
    for (int i = 8; i >= 0; i--) begin
      top = r[15];
      r   = r << 1;
      if (top != d[i]) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [8:0] pix_of(input int pat, input int x, input int y);
    if (pat == PAT_BLACK) return 9'd0;
    return {x[2:0], y[2:0], x[5:3]};
  endfunction

  // One pixel-clock sample, then cen_gap MCLKs with CEN low and junk on the bus.
  task automatic sample(input logic s_en, input logic [8:0] s_pix);
    @(negedge clk);
    cen = 1'b1;
    en  = s_en;
    rgb = s_pix;
    for (int k = 0; k < cen_gap; k++) begin
      @(negedge clk);
      cen = 1'b0;
      en  = 1'($urandom);
      rgb = 9'($urandom);
    end
  endtask

  task automatic do_reset(input int tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cen   = 1'b0;
    #1;
    check($sformatf("rst%0d_valid", tag), 32'(o_valid), 32'd0);
    check($sformatf("rst%0d_crc",   tag), 32'(o_crc),   32'd0);
    check($sformatf("rst%0d_lines", tag), 32'(o_lines), 32'd0);
    check($sformatf("rst%0d_pix",   tag), 32'(o_pix),   32'd0);
    check($sformatf("rst%0d_err_w", tag), 32'(o_err_w), 32'd0);
    check($sformatf("rst%0d_err_h", tag), 32'(o_err_h), 32'd0);
    check($sformatf("rst%0d_num",   tag), 32'(o_num),   32'd0);
    exp_num = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input frame_vec_t v, input int id);
    logic [15:0] crc;
    logic [8:0]  px;
    int          w;
    sb_entry_t   e;
    crc = 16'hFFFF;
    for (int y = 0; y < v.lines; y++) begin
      w = (y == v.bad_line) ? v.bad_w : v.width;
      for (int x = 0; x < w; x++) begin
        px  = pix_of(v.pattern, x, y);
        crc = model_crc(crc, px);
        sample(1'b1, px);
      end
      if (y != v.lines - 1)
        for (int k = 0; k < v.hblank; k++) sample(1'b0, 9'($urandom));
    end
    if (v.reported) begin
      exp_num = exp_num + 16'd1;
      e.id = id;  e.crc = crc;  e.lines = v.exp_lines;  e.pix = v.exp_pix;
      e.err_w = v.exp_err_w;  e.err_h = v.exp_err_h;  e.num = exp_num;
      sb_q.push_back(e);
    end
    for (int k = 0; k < VBL; k++) sample(1'b0, 9'($urandom));
  endtask

  // Scoreboard: every valid pulse pops the next expected frame.
  always @(posedge clk) begin
    #1;
    if (o_valid === 1'b1) begin
      check("valid_width", 32'(prev_valid), 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: actual=pulse num=%0h required=no pulse", o_num);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("f%0d_crc",   mon_e.id), 32'(o_crc),   32'(mon_e.crc));
        check($sformatf("f%0d_lines", mon_e.id), 32'(o_lines), 32'(mon_e.lines));
        check($sformatf("f%0d_pix",   mon_e.id), 32'(o_pix),   32'(mon_e.pix));
        check($sformatf("f%0d_err_w", mon_e.id), 32'(o_err_w), 32'(mon_e.err_w));
        check($sformatf("f%0d_err_h", mon_e.id), 32'(o_err_h), 32'(mon_e.err_h));
        check($sformatf("f%0d_num",   mon_e.id), 32'(o_num),   32'(mon_e.num));
        seen_crc[mon_e.id] = o_crc;
      end
    end
    prev_valid = o_valid;
  end

  initial begin
    n_checks = 0;  n_errors = 0;  cen_gap = 0;  exp_num = 16'd0;
    prev_valid = 1'b0;
    rst_n = 1'b0;  cen = 1'b0;  en = 1'b0;  rgb = 9'd0;
    for (int i = 0; i < 16; i++) seen_crc[i] = 16'd0;

    //          rst   gap lines  w   hb  bad bw  pattern    rep   lines    pix    ew    eh
    vecs[0]  = '{1'b1, 0, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b0, 10'd0,   10'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 0, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b1, 10'd12,  10'd16, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 0, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b1, 10'd12,  10'd16, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 0, TH,   TW, 8,  -1, 0,  PAT_BLACK, 1'b1, 10'd12,  10'd16, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 0, TH,   TW, 8,  5,  15, PAT_GRAD,  1'b1, 10'd12,  10'd16, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 0, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b1, 10'd12,  10'd16, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 0, 11,   TW, 8,  -1, 0,  PAT_GRAD,  1'b1, 10'd11,  10'd16, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 0, 1200, 4,  2,  -1, 0,  PAT_GRAD,  1'b1, 10'd1023, 10'd4, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 0, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b1, 10'd12,  10'd16, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 6, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b0, 10'd0,   10'd0,  1'b0, 1'b0};
    vecs[10] = '{1'b0, 6, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b1, 10'd12,  10'd16, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 6, TH,   TW, 8,  -1, 0,  PAT_GRAD,  1'b1, 10'd12,  10'd16, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_before) do_reset(i);
      cen_gap = vecs[i].cen_gap;
      send_frame(vecs[i], i);
    end

    // Reset asserted mid-line 5; the rest of that frame must never be reported.
    cen_gap = 0;
    for (int y = 0; y < TH; y++) begin
      for (int x = 0; x < TW; x++) begin
        if (y == 5 && x == 8) do_reset(12);
        sample(1'b1, pix_of(PAT_GRAD, x, y));
      end
      if (y != TH - 1)
        for (int k = 0; k < 8; k++) sample(1'b0, 9'($urandom));
    end
    for (int k = 0; k < VBL; k++) sample(1'b0, 9'($urandom));
    tail = vecs[1];
    send_frame(tail, 12);

    @(negedge clk);
    cen = 1'b0;
    repeat (5) @(negedge clk);

    check("sb_pending", 32'(sb_q.size()), 32'd0);
    check("crc_repeat_same", 32'(seen_crc[2]), 32'(seen_crc[1]));
    check("crc_black_vs_grad_differ", 32'(seen_crc[3] != seen_crc[1]), 32'd1);
    check("crc_sparse_cen_same", 32'(seen_crc[10]), 32'(seen_crc[1]));
    check("crc_after_midreset_same", 32'(seen_crc[12]), 32'(seen_crc[1]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
